atm_rx_scheduler: RTL and testbench
===================================

ATM_RX_SCHEDULER -- requirements
Module: atm_rx_scheduler

Parameters
REQ-001 The block SHALL have parameter NUM_RX, default 4, giving the number of Utopia receive ports arbitrated (range 2..16).
REQ-002 The block SHALL have parameter TIMEOUT, default 255, giving the maximum number of HOLD cycles per grant (range 1..65535).

Interface
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low; asserted when 0.
REQ-005 req  input  NUM_RX  per-port cell-available request (receiver valid); bit i = port i.
REQ-006 port_en  input  NUM_RX  per-port enable mask from configuration; disabled ports never granted.
REQ-007 done  input  1  one-cycle pulse from forwarding engine: granted cell fully consumed.
REQ-008 grant  output  NUM_RX  one-hot grant (receiver ready-low select); all-zero when no grant.
REQ-009 grant_idx  output  max(1,$clog2(NUM_RX))  binary index of granted port; valid only while grant_valid=1.
REQ-010 grant_valid  output  1  high while any grant bit is high.
REQ-011 abort  output  1  one-cycle pulse: granted port dropped req before done.
REQ-012 timeout_err  output  1  one-cycle pulse: HOLD exceeded TIMEOUT cycles.
REQ-013 grant_cnt  output  16  count of completed grants (done accepted); saturates at 16'hFFFF.

Function
REQ-014 FSM states SHALL be IDLE, HOLD, RECOVER; encoding is free.
REQ-015 Eligible set SHALL be req & port_en, sampled at the clock edge.
REQ-016 IDLE: if eligible set nonzero, the block SHALL register a grant to the first eligible port at or after rr_ptr (wrapping NUM_RX-1 -> 0) and enter HOLD; grant visible the cycle after req seen (latency 1).
REQ-017 IDLE with empty eligible set SHALL remain IDLE, grant=0.
REQ-018 rr_ptr SHALL update to (granted index + 1) mod NUM_RX when a grant is issued; lowest index wins only relative to rr_ptr.
REQ-019 HOLD: grant, grant_idx SHALL stay constant; hold counter increments every HOLD cycle starting from 1 on the first.
REQ-020 HOLD with done=1 SHALL clear grant, increment grant_cnt (saturating), enter RECOVER.
REQ-021 HOLD with done=0 and granted port's req=0 SHALL pulse abort, clear grant, enter RECOVER; grant_cnt unchanged.
REQ-022 HOLD with done=0, req held, hold counter = TIMEOUT SHALL pulse timeout_err, clear grant, enter RECOVER.
REQ-023 Simultaneous done and req drop, or done and timeout, in the same cycle SHALL be treated as done only (no abort/timeout_err).
REQ-024 Clearing port_en for the granted port during HOLD SHALL NOT affect the current grant; it masks only future arbitration.
REQ-025 RECOVER SHALL last exactly one cycle with grant=0, then return to IDLE; minimum spacing between grants is 2 idle-grant cycles.
REQ-026 done pulses in IDLE or RECOVER SHALL be ignored (no count, no state change).
REQ-027 abort and timeout_err SHALL be registered, high for exactly one cycle, never both high together.
REQ-028 grant SHALL never have more than one bit set; grant_valid SHALL equal |grant.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, grant=0, grant_idx=0, grant_valid=0, abort=0, timeout_err=0, grant_cnt=0, rr_ptr=0, hold counter=0.
REQ-030 Reset asserted mid-HOLD SHALL drop grant asynchronously with no abort/timeout_err pulse; first grant after release follows REQ-016 from rr_ptr=0.
REQ-031 Outputs SHALL be driven from registers only.

Verification
REQ-032 NUM_RX=4, req=4'b1111, port_en=4'b1111, done 3 cycles after each grant -> grants in order ports 0,1,2,3,0; grant_cnt=5.
REQ-033 rr_ptr=2 (after granting 1), req=4'b0011 -> wrap-around grant to port 0, then port 1 next.
REQ-034 port_en=4'b1011, req=4'b0100 only -> no grant ever; grant_valid stays 0.
REQ-035 TIMEOUT=5, grant port 1, no done, req held -> timeout_err pulses on 5th HOLD cycle, grant=0 next cycle, grant_cnt unchanged.
REQ-036 Grant port 2, drop req[2] in HOLD with done=0 -> abort one-cycle pulse; same-cycle done+drop -> no abort, grant_cnt+1.
REQ-037 rst=0 mid-HOLD -> grant=0 within the same cycle (asynchronously), grant_cnt=0, then first post-reset grant to lowest eligible index.

Source files
------------

// File: rtl/atm_rx_scheduler_if.sv
// Request/grant bundle between the Utopia receive ports and the RX cell scheduler.
interface atm_rx_scheduler_if #(
  parameter int NUM_RX = 4
);
  localparam int IDX_W = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;

  logic [NUM_RX-1:0] req;
  logic [NUM_RX-1:0] port_en;
  logic              done;
  logic [NUM_RX-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;
  logic              abort;
  logic              timeout_err;
  logic [15:0]       grant_cnt;

  modport master (
    input  req, port_en, done,
    output grant, grant_idx, grant_valid, abort, timeout_err, grant_cnt
  );

  modport slave (
    output req, port_en, done,
    input  grant, grant_idx, grant_valid, abort, timeout_err, grant_cnt
  );
endinterface

// File: rtl/atm_rx_scheduler.sv
// Round-robin arbiter granting one Utopia receive port at a time until the
// forwarding engine consumes the cell, the port drops its request, or a hold timeout expires.
module atm_rx_scheduler #(
  parameter int NUM_RX  = 4,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  atm_rx_scheduler_if.master bus
);
  localparam int               IDX_W    = (NUM_RX > 1) ? $clog2(NUM_RX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RX - 1);
  localparam logic [15:0]      HOLD_MAX = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, HOLD, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [NUM_RX-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              gv_q, gv_d;
  logic              abort_q, abort_d;
  logic              tout_q, tout_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [15:0]       hold_q, hold_d;
  logic              release_grant;

  logic [NUM_RX-1:0] elig;
  logic              pick_vld;
  logic [IDX_W-1:0]  pick_idx;

  // Scan from the highest offset down so the port nearest rr_ptr wins.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_RX-1:0] e,
                                             input logic [IDX_W-1:0]  ptr);
    logic [IDX_W:0]   r;
    logic [IDX_W-1:0] p;
    r = '0;
    for (int k = NUM_RX - 1; k >= 0; k--) begin
      p = IDX_W'((int'(ptr) + k) % NUM_RX);
      if (e[p]) r = {1'b1, p};
    end
    return r;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign elig                = bus.req & bus.port_en;
  assign {pick_vld, pick_idx} = rr_pick(elig, rr_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    idx_d         = idx_q;
    gv_d          = gv_q;
    abort_d       = 1'b0;
    tout_d        = 1'b0;
    cnt_d         = cnt_q;
    rr_d          = rr_q;
    hold_d        = hold_q;
    release_grant = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d           = HOLD;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          gv_d              = 1'b1;
          rr_d              = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
          hold_d            = 16'd1;
        end
      end
      HOLD: begin
        // done outranks both a request drop and an expiring hold counter.
        if (bus.done) begin
          cnt_d         = sat_inc(cnt_q);
          release_grant = 1'b1;
        end else if (!bus.req[idx_q]) begin
          abort_d       = 1'b1;
          release_grant = 1'b1;
        end else if (hold_q == HOLD_MAX) begin
          tout_d        = 1'b1;
          release_grant = 1'b1;
        end else begin
          hold_d = hold_q + 16'd1;
        end
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (release_grant) begin
      state_d = RECOVER;
      grant_d = '0;
      gv_d    = 1'b0;
      hold_d  = 16'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      gv_q    <= 1'b0;
      abort_q <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= 16'd0;
      rr_q    <= '0;
      hold_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      gv_q    <= gv_d;
      abort_q <= abort_d;
      tout_q  <= tout_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = gv_q;
  assign bus.abort       = abort_q;
  assign bus.timeout_err = tout_q;
  assign bus.grant_cnt   = cnt_q;
endmodule

// File: tb/tb_atm_rx_scheduler.sv
// Scoreboard bench for atm_rx_scheduler: directed stimulus queues expected grant
// start/end events; a negedge monitor pops them when the grant rises or falls.
module tb_atm_rx_scheduler;
  localparam int NUM_RX  = 4;
  localparam int TIMEOUT = 5;
  localparam int EV_GRANT = 0, EV_DONE = 1, EV_ABORT = 2, EV_TOUT = 3, EV_RST = 4;

  typedef struct {
    int kind;
    int idx;
    int cnt;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  sb[$];
  ev_t  mon_e;
  logic              prev_gv = 1'b0;
  logic [NUM_RX-1:0] prev_grant = '0;
  logic [NUM_RX-1:0] exp_g;
  int   g;

  atm_rx_scheduler_if #(.NUM_RX(NUM_RX)) bus ();

  atm_rx_scheduler #(.NUM_RX(NUM_RX), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int idx, input int cnt, input int at);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cnt  = cnt;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in an IDLE cycle with the eligible set already driven.
  task automatic cycle_done(input int idx, input int cnt, input int hold);
    int gc;
    gc = cyc + 1;
    push(EV_GRANT, idx, 0, gc);
    repeat (hold) tick();
    bus.done = 1'b1;
    push(EV_DONE, idx, cnt, gc + hold);
    tick();
    bus.done = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    chk("grant_onehot0", 32'($onehot0(bus.grant)), 32'd1);
    chk("grant_valid_eq_or", 32'(bus.grant_valid), 32'(|bus.grant));
    if (bus.grant_valid && !prev_gv) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_grant: got port %0d, expected no grant (cycle %0d)", bus.grant_idx, cyc);
      end else begin
        mon_e = sb.pop_front();
        exp_g = NUM_RX'(1) << mon_e.idx;
        chk("event_is_grant", 32'(EV_GRANT), 32'(mon_e.kind));
        chk("grant_idx", 32'(bus.grant_idx), 32'(mon_e.idx));
        chk("grant_vec", 32'(bus.grant), 32'(exp_g));
        chk("grant_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else if (!bus.grant_valid && prev_gv) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_release: got grant drop, expected grant held (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("event_is_release", 32'(mon_e.kind != EV_GRANT), 32'd1);
        chk("abort_pulse", 32'(bus.abort), 32'(mon_e.kind == EV_ABORT));
        chk("timeout_pulse", 32'(bus.timeout_err), 32'(mon_e.kind == EV_TOUT));
        chk("grant_cnt", 32'(bus.grant_cnt), 32'(mon_e.cnt));
        chk("release_cycle", 32'(cyc), 32'(mon_e.cyc));
      end
    end else begin
      chk("no_stray_pulse", 32'({bus.abort, bus.timeout_err}), 32'd0);
      if (bus.grant_valid) chk("grant_stable", 32'(bus.grant), 32'(prev_grant));
    end
    prev_gv    <= bus.grant_valid;
    prev_grant <= bus.grant;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got no completion, expected finish within 20000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst         = 1'b1;
    bus.req     = '0;
    bus.port_en = '0;
    bus.done    = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_grant_idx", 32'(bus.grant_idx), 32'd0);
    chk("rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("rst_abort", 32'(bus.abort), 32'd0);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    chk("rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
    rst = 1'b1;
    tick();

    // Full round robin over all ports.
    bus.req     = 4'b1111;
    bus.port_en = 4'b1111;
    cycle_done(0, 1, 3);
    cycle_done(1, 2, 3);
    cycle_done(2, 3, 3);
    cycle_done(3, 4, 3);
    cycle_done(0, 5, 3);

    // Wrap-around from rr_ptr=2.
    bus.req = 4'b0010;
    cycle_done(1, 6, 3);
    bus.req = 4'b0011;
    cycle_done(0, 7, 3);
    cycle_done(1, 8, 3);

    // Disabled requester is never granted; done in IDLE is ignored.
    bus.port_en = 4'b1011;
    bus.req     = 4'b0100;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.done = (i == 3);
      chk("disabled_no_grant", 32'(bus.grant_valid), 32'd0);
    end
    bus.done = 1'b0;

    // Masking the granted port mid-hold keeps the current grant.
    bus.port_en = 4'b1111;
    bus.req     = 4'b1000;
    g = cyc + 1;
    push(EV_GRANT, 3, 0, g);
    tick();
    bus.port_en = 4'b0111;
    tick();
    bus.done = 1'b1;
    push(EV_DONE, 3, 9, g + 2);
    tick();
    bus.done = 1'b0;
    tick();

    // Hold timeout; done during RECOVER is ignored.
    bus.port_en = 4'b1111;
    bus.req     = 4'b0010;
    g = cyc + 1;
    push(EV_GRANT, 1, 0, g);
    push(EV_TOUT, 1, 9, g + 5);
    repeat (6) tick();
    bus.req  = '0;
    bus.done = 1'b1;
    tick();
    bus.done = 1'b0;

    // Request drop aborts; done together with a drop counts as done.
    bus.req = 4'b0100;
    g = cyc + 1;
    push(EV_GRANT, 2, 0, g);
    tick();
    tick();
    bus.req = '0;
    push(EV_ABORT, 2, 9, g + 2);
    tick();
    tick();
    bus.req = 4'b0100;
    g = cyc + 1;
    push(EV_GRANT, 2, 0, g);
    tick();
    tick();
    bus.done = 1'b1;
    bus.req  = '0;
    push(EV_DONE, 2, 10, g + 2);
    tick();
    bus.done = 1'b0;
    tick();

    // Asynchronous reset in HOLD, then arbitration restarts from port 0.
    bus.req = 4'b1010;
    g = cyc + 1;
    push(EV_GRANT, 3, 0, g);
    tick();
    tick();
    push(EV_RST, 3, 0, g + 1);
    rst = 1'b0;
    #1;
    chk("async_rst_grant", 32'(bus.grant), 32'd0);
    chk("async_rst_grant_valid", 32'(bus.grant_valid), 32'd0);
    chk("async_rst_grant_cnt", 32'(bus.grant_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b1;
    cycle_done(1, 1, 3);

    bus.req = '0;
    repeat (3) tick();
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
